// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM responder.
// Imported by the responder top and its storage array.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } dram_state_t;

  localparam logic LSU_LOAD  = 1'b0;
  localparam logic LSU_STORE = 1'b1;

  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/dram_storage.sv
// Word array with per-word valid bits; unwritten words
// read back as their own index, zero-extended.
module dram_storage
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  // Contents survive reset; only validity is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  always_comb begin
    o_rdata = DATA_WIDTH'(i_idx);
    if (r_valid[i_idx]) begin
      o_rdata = r_mem[i_idx];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: captures a cache-miss request, waits
// a fixed latency, then returns one mem_ready strobe with data.
module dram_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int TAG_WIDTH  = 20,
  parameter int ADDR_BITS  = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic                  lsu_operator,
  input  logic                  mem_req,
  input  logic [DATA_WIDTH-1:0] write_data_int,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] dram_data_out,
  output logic                  busy
);

  localparam int CNT_W =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("dram_responder: LATENCY must be >= 1");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("dram_responder: TAG_WIDTH must be >= 1");
  end

  dram_state_t           r_state;
  dram_state_t           w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDR_BITS-1:0]  r_idx;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_capture;
  logic                  w_respond;
  logic                  w_we;
  logic                  w_unused_addr;

  assign w_idx = address[ADDR_BITS+WORD_OFFSET-1:WORD_OFFSET];
  assign w_unused_addr = ^{address[31:ADDR_BITS+WORD_OFFSET],
                           address[WORD_OFFSET-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_respond   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_respond   = 1'b1;
          w_state_nxt = RESPOND;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESPOND: w_state_nxt = RELEASE;
      RELEASE: begin
        if (!mem_req) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign w_we = w_respond && (r_op == LSU_STORE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_op    <= LSU_LOAD;
      r_wdata <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_idx   <= w_idx;
        r_op    <= lsu_operator;
        r_wdata <= write_data_int;
      end
      if (w_respond) begin
        r_dout <= (r_op == LSU_STORE) ? r_wdata : w_rdata;
      end
    end
  end

  dram_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Strobe is decoded from state so reset drops it at once.
  assign mem_ready     = (r_state == RESPOND);
  assign busy          = (r_state != IDLE);
  assign dram_data_out = r_dout;

endmodule
